// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the datapath/memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_write,
           mem_to_reg, instr_done, illegal, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_write,
           mem_to_reg, instr_done, illegal, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32 core: sequences fetch/decode/execute/mem/wb.
// Optional jal support is enabled by defining MULTICYCLE_CTRL_JAL_EN.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef MULTICYCLE_CTRL_JAL_EN
  localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
`ifdef MULTICYCLE_CTRL_JAL_EN
    ST_JAL       = 4'd9,
`endif
    ST_HALT      = 4'd15
  } state_e;

  state_e     state_r;
  state_e     next_state_s;
  logic       is_store_r;

  logic       mem_req_s;
  logic       mem_we_s;
  logic       iord_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic [1:0] pc_source_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       reg_write_s;
  logic [1:0] mem_to_reg_s;
  logic       instr_done_s;
  logic       illegal_s;
  logic [3:0] state_out_s;

  // State register; load/store kind is latched in DECODE so opcode is sampled only there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_FETCH;
      is_store_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_DECODE) begin
        is_store_r <= (bus.opcode == OP_SW);
      end else begin
        is_store_r <= is_store_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state_s = ST_MEM_ADDR;
          OP_R:         next_state_s = ST_EXECUTE;
          OP_BEQ:       next_state_s = ST_BRANCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
          OP_JAL:       next_state_s = ST_JAL;
`endif
          default:      next_state_s = ST_HALT;
        endcase
      end
      ST_MEM_ADDR: begin
        if (is_store_r) begin
          next_state_s = ST_MEM_WRITE;
        end else begin
          next_state_s = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        if (bus.mem_ready) begin
          next_state_s = ST_MEM_WB;
        end else begin
          next_state_s = ST_MEM_READ;
        end
      end
      ST_MEM_WB:  next_state_s = ST_FETCH;
      ST_MEM_WRITE: begin
        if (bus.mem_ready) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_MEM_WRITE;
        end
      end
      ST_EXECUTE: next_state_s = ST_ALU_WB;
      ST_ALU_WB:  next_state_s = ST_FETCH;
      ST_BRANCH:  next_state_s = ST_FETCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
      ST_JAL:     next_state_s = ST_FETCH;
`endif
      ST_HALT:    next_state_s = ST_HALT;
      // Unused encodings trap into HALT rather than resuming silently.
      default:    next_state_s = ST_HALT;
    endcase
  end

  // Output decode from state; everything is held at 0 while reset is asserted.
  always_comb begin
    mem_req_s       = 1'b0;
    mem_we_s        = 1'b0;
    iord_s          = 1'b0;
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_source_s     = 2'b00;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    reg_write_s     = 1'b0;
    mem_to_reg_s    = 2'b00;
    instr_done_s    = 1'b0;
    illegal_s       = 1'b0;
    state_out_s     = 4'd0;
    if (!rst_n) begin
      state_out_s = 4'd0;
    end else begin
      state_out_s = state_r;
      case (state_r)
        ST_FETCH: begin
          mem_req_s   = 1'b1;
          alu_src_b_s = 2'b01;
          ir_write_s  = bus.mem_ready;
          pc_write_s  = bus.mem_ready;
        end
        ST_DECODE: begin
          alu_src_b_s = 2'b10;
        end
        ST_MEM_ADDR: begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = 2'b10;
        end
        ST_MEM_READ: begin
          mem_req_s = 1'b1;
          iord_s    = 1'b1;
        end
        ST_MEM_WB: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = 2'b01;
          instr_done_s = 1'b1;
        end
        ST_MEM_WRITE: begin
          mem_req_s    = 1'b1;
          mem_we_s     = 1'b1;
          iord_s       = 1'b1;
          instr_done_s = bus.mem_ready;
        end
        ST_EXECUTE: begin
          alu_src_a_s = 1'b1;
          alu_op_s    = 2'b10;
        end
        ST_ALU_WB: begin
          reg_write_s  = 1'b1;
          instr_done_s = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a_s     = 1'b1;
          alu_op_s        = 2'b01;
          pc_write_cond_s = 1'b1;
          pc_source_s     = 2'b01;
          instr_done_s    = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_JAL_EN
        // PC already holds PC+4 here, so it is the link value.
        ST_JAL: begin
          pc_write_s   = 1'b1;
          pc_source_s  = 2'b01;
          reg_write_s  = 1'b1;
          mem_to_reg_s = 2'b10;
          instr_done_s = 1'b1;
        end
`endif
        ST_HALT: begin
          illegal_s = 1'b1;
        end
        default: begin
          illegal_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req       = mem_req_s;
  assign bus.mem_we        = mem_we_s;
  assign bus.iord          = iord_s;
  assign bus.ir_write      = ir_write_s;
  assign bus.pc_write      = pc_write_s;
  assign bus.pc_write_cond = pc_write_cond_s;
  assign bus.pc_source     = pc_source_s;
  assign bus.alu_src_a     = alu_src_a_s;
  assign bus.alu_src_b     = alu_src_b_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.reg_write     = reg_write_s;
  assign bus.mem_to_reg    = mem_to_reg_s;
  assign bus.instr_done    = instr_done_s;
  assign bus.illegal       = illegal_s;
  assign bus.state_o       = state_out_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and packed control-vector checks.
module tb_multicycle_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source[1:0],
  //  alu_src_a, alu_src_b[1:0], alu_op[1:0], reg_write, mem_to_reg[1:0], instr_done, illegal}
  logic [17:0] ctl;
  assign ctl = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.reg_write, bus.mem_to_reg, bus.instr_done, bus.illegal};

  localparam logic [17:0] V_ZERO     = 18'b0_0_0_0_0_0_00_0_00_00_0_00_0_0;
  localparam logic [17:0] V_FETCH_R  = 18'b1_0_0_1_1_0_00_0_01_00_0_00_0_0;
  localparam logic [17:0] V_FETCH_W  = 18'b1_0_0_0_0_0_00_0_01_00_0_00_0_0;
  localparam logic [17:0] V_DECODE   = 18'b0_0_0_0_0_0_00_0_10_00_0_00_0_0;
  localparam logic [17:0] V_MEM_ADDR = 18'b0_0_0_0_0_0_00_1_10_00_0_00_0_0;
  localparam logic [17:0] V_MEM_READ = 18'b1_0_1_0_0_0_00_0_00_00_0_00_0_0;
  localparam logic [17:0] V_MEM_WB   = 18'b0_0_0_0_0_0_00_0_00_00_1_01_1_0;
  localparam logic [17:0] V_MEMW_W   = 18'b1_1_1_0_0_0_00_0_00_00_0_00_0_0;
  localparam logic [17:0] V_MEMW_R   = 18'b1_1_1_0_0_0_00_0_00_00_0_00_1_0;
  localparam logic [17:0] V_EXECUTE  = 18'b0_0_0_0_0_0_00_1_00_10_0_00_0_0;
  localparam logic [17:0] V_ALU_WB   = 18'b0_0_0_0_0_0_00_0_00_00_1_00_1_0;
  localparam logic [17:0] V_BRANCH   = 18'b0_0_0_0_0_1_01_1_00_01_0_00_1_0;
  localparam logic [17:0] V_JAL      = 18'b0_0_0_0_1_0_01_0_00_00_1_10_1_0;
  localparam logic [17:0] V_HALT     = 18'b0_0_0_0_0_0_00_0_00_00_0_00_0_1;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs on the falling edge, then check state and controls.
  task automatic cyc(input string tag, input logic rst_v, input logic rdy,
                     input logic [6:0] op, input logic [3:0] exp_st,
                     input logic [17:0] exp_v);
    @(negedge clk);
    rst_n         = rst_v;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    #1;
    chk({tag, "_state"}, {28'd0, bus.state_o}, {28'd0, exp_st});
    chk({tag, "_ctl"}, {14'd0, ctl}, {14'd0, exp_v});
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_BAD;

    // Reset state
    cyc("reset0", 1'b0, 1'b1, OP_BAD, 4'd0, V_ZERO);
    cyc("reset1", 1'b0, 1'b1, OP_BAD, 4'd0, V_ZERO);

    // lw, zero-wait: 0,1,2,3,4
    cyc("lw_fetch",   1'b1, 1'b1, OP_LW, 4'd0, V_FETCH_R);
    cyc("lw_decode",  1'b1, 1'b1, OP_LW, 4'd1, V_DECODE);
    cyc("lw_addr",    1'b1, 1'b1, OP_BAD, 4'd2, V_MEM_ADDR);
    cyc("lw_read",    1'b1, 1'b1, OP_BAD, 4'd3, V_MEM_READ);
    cyc("lw_wb",      1'b1, 1'b1, OP_BAD, 4'd4, V_MEM_WB);

    // sw with one fetch wait and three MEM_WRITE waits
    cyc("sw_fetch_w", 1'b1, 1'b0, OP_SW, 4'd0, V_FETCH_W);
    cyc("sw_fetch",   1'b1, 1'b1, OP_SW, 4'd0, V_FETCH_R);
    cyc("sw_decode",  1'b1, 1'b0, OP_SW, 4'd1, V_DECODE);
    cyc("sw_addr",    1'b1, 1'b0, OP_LW, 4'd2, V_MEM_ADDR);
    for (int i = 0; i < 3; i++) begin
      cyc("sw_wait",  1'b1, 1'b0, OP_LW, 4'd5, V_MEMW_W);
    end
    cyc("sw_done",    1'b1, 1'b1, OP_LW, 4'd5, V_MEMW_R);

    // R-type then beq back-to-back: 7 cycles
    cyc("r_fetch",    1'b1, 1'b1, OP_R, 4'd0, V_FETCH_R);
    cyc("r_decode",   1'b1, 1'b1, OP_R, 4'd1, V_DECODE);
    cyc("r_exec",     1'b1, 1'b0, OP_BAD, 4'd6, V_EXECUTE);
    cyc("r_wb",       1'b1, 1'b0, OP_BAD, 4'd7, V_ALU_WB);
    cyc("b_fetch",    1'b1, 1'b1, OP_BEQ, 4'd0, V_FETCH_R);
    cyc("b_decode",   1'b1, 1'b1, OP_BEQ, 4'd1, V_DECODE);
    cyc("b_branch",   1'b1, 1'b0, OP_BAD, 4'd8, V_BRANCH);
    cyc("b_next",     1'b1, 1'b0, OP_BAD, 4'd0, V_FETCH_W);

    // jal: 3 cycles with the feature built, HALT otherwise
    cyc("j_fetch",    1'b1, 1'b1, OP_JAL, 4'd0, V_FETCH_R);
    cyc("j_decode",   1'b1, 1'b1, OP_JAL, 4'd1, V_DECODE);
`ifdef MULTICYCLE_CTRL_JAL_EN
    cyc("j_jal",      1'b1, 1'b1, OP_BAD, 4'd9, V_JAL);
    cyc("j_next",     1'b1, 1'b0, OP_BAD, 4'd0, V_FETCH_W);
`else
    cyc("j_halt",     1'b1, 1'b1, OP_BAD, 4'd15, V_HALT);
    cyc("j_halt2",    1'b1, 1'b1, OP_BAD, 4'd15, V_HALT);
`endif
    cyc("j_rst",      1'b0, 1'b1, OP_BAD, 4'd0, V_ZERO);

    // Illegal opcode: HALT held 20 cycles, reset returns to FETCH
    cyc("ill_fetch",  1'b1, 1'b1, OP_BAD, 4'd0, V_FETCH_R);
    cyc("ill_decode", 1'b1, 1'b1, OP_BAD, 4'd1, V_DECODE);
    for (int i = 0; i < 20; i++) begin
      cyc("ill_halt", 1'b1, i[0], OP_LW, 4'd15, V_HALT);
    end
    cyc("ill_rst",    1'b0, 1'b1, OP_BAD, 4'd0, V_ZERO);
    cyc("ill_fetch2", 1'b1, 1'b1, OP_LW, 4'd0, V_FETCH_R);

    // Reset during MEM_READ wait aborts immediately
    cyc("ab_decode",  1'b1, 1'b1, OP_LW, 4'd1, V_DECODE);
    cyc("ab_addr",    1'b1, 1'b1, OP_BAD, 4'd2, V_MEM_ADDR);
    cyc("ab_wait1",   1'b1, 1'b0, OP_BAD, 4'd3, V_MEM_READ);
    cyc("ab_wait2",   1'b1, 1'b0, OP_BAD, 4'd3, V_MEM_READ);
    cyc("ab_rst",     1'b0, 1'b1, OP_BAD, 4'd0, V_ZERO);
    cyc("ab_fetch",   1'b1, 1'b0, OP_BAD, 4'd0, V_FETCH_W);
    cyc("ab_fetch2",  1'b1, 1'b1, OP_BAD, 4'd0, V_FETCH_R);
    cyc("ab_decode2", 1'b1, 1'b1, OP_BAD, 4'd1, V_DECODE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
